// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = fifo_arb_pkg::NUM_REQ,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    index
);

    logic [ID_W-1:0]    cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_req;

    // cand_idx[k] is the requester visited k steps after rr_ptr
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rotate
            assign cand_idx[gi] = ID_W'((int'(rr_ptr) + gi) % NUM_REQ);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the far end so the closest candidate wins
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                found = 1'b1;
                index = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one FIFO write port; a winner keeps the port
// until its last beat or MAX_BURST beats, whichever comes first.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = fifo_arb_pkg::NUM_REQ,
    parameter int DATA_WIDTH = fifo_arb_pkg::DATA_WIDTH,
    parameter int MAX_BURST  = fifo_arb_pkg::MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full_flag,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          wr_enb,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    active_id
);

    import fifo_arb_pkg::*;

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_t       state_reg, state_next;
    logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]  owner_reg, owner_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic            pick_found;
    logic [ID_W-1:0] pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .found  (pick_found),
        .index  (pick_idx)
    );

    // Reset and a full FIFO both freeze everything by skipping the case entirely
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        owner_next    = owner_reg;
        beat_cnt_next = beat_cnt_reg;
        gnt           = '0;
        if (!rst && !full_flag) begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        gnt[pick_idx] = 1'b1;
                        owner_next    = pick_idx;
                        beat_cnt_next = CNT_ONE;
                        if (last[pick_idx] || MAX_BURST == 1) begin
                            rr_ptr_next = ID_W'((int'(pick_idx) + 1) % NUM_REQ);
                        end else begin
                            state_next = BURST;
                        end
                    end
                end
                BURST: begin
                    if (req[owner_reg]) begin
                        gnt[owner_reg] = 1'b1;
                        beat_cnt_next  = beat_cnt_reg + CNT_ONE;
                        if (last[owner_reg] || beat_cnt_next == CNT_MAX) begin
                            state_next  = IDLE;
                            rr_ptr_next = ID_W'((int'(owner_reg) + 1) % NUM_REQ);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            owner_reg    <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            owner_reg    <= owner_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // gnt is one-hot, so an AND-OR mux yields the winner's data or zero
    logic [DATA_WIDTH-1:0] masked_data [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign masked_data[gi] = {DATA_WIDTH{gnt[gi]}} & req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        wr_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            wr_data = wr_data | masked_data[k];
        end
    end

    assign wr_enb    = |gnt;
    assign busy      = !rst && (state_reg == BURST);
    assign active_id = rst ? '0 : owner_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios then random traffic.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int IW = 2;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR-1:0]     last;
    logic [NR*DW-1:0]  req_data;
    logic              full_flag;
    logic [NR-1:0]     gnt;
    logic              wr_enb;
    logic [DW-1:0]     wr_data;
    logic              busy;
    logic [IW-1:0]     active_id;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .req_data  (req_data),
        .full_flag (full_flag),
        .gnt       (gnt),
        .wr_enb    (wr_enb),
        .wr_data   (wr_data),
        .busy      (busy),
        .active_id (active_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] gnt;
        logic          we;
        logic [DW-1:0] data;
        logic          busy;
        logic [IW-1:0] aid;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] wr_q  [$];
    int            n_checks = 0;
    int            n_fail   = 0;

    // Reference model: who holds the port, beats taken, and where the next search starts
    bit m_locked = 0;
    int m_owner  = 0;
    int m_cnt    = 0;
    int m_ptr    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] l,
                        input logic f, input logic rs, input logic [NR*DW-1:0] d);
        exp_t e;
        int   g;
        @(negedge clk);
        req = r; last = l; full_flag = f; rst = rs; req_data = d;
        e.gnt = '0; e.we = 1'b0; e.data = '0; e.busy = 1'b0; e.aid = '0;
        g = -1;
        if (rs) begin
            m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        end else begin
            e.busy = m_locked;
            e.aid  = IW'(m_owner);
            if (!f) begin
                if (!m_locked) begin
                    for (int k = 0; k < NR; k++)
                        if (g < 0 && r[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
                    if (g >= 0) begin
                        m_owner = g;
                        m_cnt   = 1;
                        if (l[g] || MB == 1) m_ptr = (g + 1) % NR;
                        else m_locked = 1;
                    end
                end else if (r[m_owner]) begin
                    g = m_owner;
                    m_cnt++;
                    if (l[g] || m_cnt == MB) begin
                        m_locked = 0;
                        m_ptr    = (g + 1) % NR;
                    end
                end
                if (g >= 0) begin
                    e.gnt[g] = 1'b1;
                    e.we     = 1'b1;
                    e.data   = d[g*DW +: DW];
                    wr_q.push_back(e.data);
                end
            end
        end
        exp_q.push_back(e);
    endtask

    function automatic logic [NR*DW-1:0] rnd_data();
        return NR*DW'($urandom);
    endfunction

    // Monitor: per-cycle expectations, plus the write stream whenever wr_enb is seen
    initial begin
        exp_t          e;
        logic [DW-1:0] w;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("wr_enb", 32'(wr_enb), 32'(e.we));
                chk("wr_data", 32'(wr_data), 32'(e.data));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("active_id", 32'(active_id), 32'(e.aid));
                if (wr_enb) begin
                    if (wr_q.size() == 0) begin
                        chk("unexpected_write", 32'(wr_data), 32'hDEAD_BEEF);
                    end else begin
                        w = wr_q.pop_front();
                        chk("write_stream", 32'(wr_data), 32'(w));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req = '0; last = '0; full_flag = 1'b0; req_data = '0;

        // Reset overrides active requests
        step(4'b1111, 4'b1111, 1'b0, 1'b1, rnd_data());
        step(4'b1111, 4'b0000, 1'b0, 1'b1, rnd_data());

        // Single beat from requester 0
        step(4'b0001, 4'b0001, 1'b0, 1'b0, {24'h123456, 8'hA5});

        // Round robin of single-beat bursts from index 0
        step(4'b0000, 4'b0000, 1'b0, 1'b1, rnd_data());
        repeat (5) step(4'b1111, 4'b1111, 1'b0, 1'b0, rnd_data());

        // Burst cap on requester 2 while requester 1 waits
        step(4'b0100, 4'b0000, 1'b0, 1'b0, rnd_data());
        repeat (4) step(4'b0110, 4'b0000, 1'b0, 1'b0, rnd_data());
        step(4'b0010, 4'b0010, 1'b0, 1'b0, rnd_data());

        // Full backpressure on beat 2
        step(4'b0001, 4'b0000, 1'b0, 1'b0, rnd_data());
        step(4'b0001, 4'b0000, 1'b1, 1'b0, rnd_data());
        step(4'b0001, 4'b0000, 1'b0, 1'b0, rnd_data());
        step(4'b0001, 4'b0001, 1'b0, 1'b0, rnd_data());

        // Owner stall while another requester is pending
        step(4'b0010, 4'b0000, 1'b0, 1'b0, rnd_data());
        repeat (3) step(4'b1000, 4'b1000, 1'b0, 1'b0, rnd_data());
        step(4'b0010, 4'b0010, 1'b0, 1'b0, rnd_data());

        // Reset mid-burst, then arbitration restarts at index 0
        step(4'b1000, 4'b0000, 1'b0, 1'b0, rnd_data());
        step(4'b1011, 4'b0000, 1'b0, 1'b1, rnd_data());
        step(4'b1010, 4'b0000, 1'b0, 1'b0, rnd_data());

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step(NR'($urandom), NR'($urandom) & NR'($urandom),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 99) == 0), rnd_data());
        end

        step(4'b0000, 4'b0000, 1'b0, 1'b0, rnd_data());
        @(negedge clk);
        #5;
        chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("write_queue_drained", 32'(wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
